// File: rtl/led_pkg.sv
// Shared defaults and types for the LED afterglow PWM block.
package led_pkg;

   localparam int N_LEDS_DEF        = 8;
   localparam int PWM_BITS_DEF      = 8;
   localparam int FADE_DIV_LOG2_DEF = 16;
   localparam int FADE_STEP_DEF     = 8;

   typedef logic [PWM_BITS_DEF-1:0] level_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: request flop, fading brightness level, period-latched duty
// and registered PWM compare.
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS  = PWM_BITS_DEF,
   parameter int FADE_STEP = FADE_STEP_DEF
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pattern_bit,
   input  logic [PWM_BITS-1:0] bright_max,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                boundary,
   input  logic                fade_tick,
   output logic                led
);

   localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);

   logic                pattern_q_r;
   logic [PWM_BITS-1:0] level_r;
   logic [PWM_BITS-1:0] level_nxt_s;
   logic [PWM_BITS-1:0] duty_r;
   logic                led_r;

   // Level update: a lit request wins over a fade step; a lowered cap clamps fading LEDs.
   always_comb begin
      level_nxt_s = level_r;
      if (pattern_q_r) begin
         level_nxt_s = bright_max;
      end else if (fade_tick) begin
         level_nxt_s = (level_r > STEP) ? (level_r - STEP) : {PWM_BITS{1'b0}};
      end else if (level_r > bright_max) begin
         level_nxt_s = bright_max;
      end else begin
         level_nxt_s = level_r;
      end
   end

   // Channel state; duty only changes at the period boundary so pulses are never cut.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_q_r <= 1'b0;
         level_r     <= {PWM_BITS{1'b0}};
         duty_r      <= {PWM_BITS{1'b0}};
         led_r       <= 1'b0;
      end else begin
         pattern_q_r <= pattern_bit;
         level_r     <= level_nxt_s;
         if (boundary) begin
            duty_r <= level_r;
         end
         led_r       <= (pwm_cnt < duty_r);
      end
   end

   assign led = led_r;

endmodule

// File: rtl/led_afterglow_pwm.sv
// LED bank driver: shared PWM counter and fade prescaler feeding one
// independent fading PWM channel per LED.
module led_afterglow_pwm
   import led_pkg::*;
#(
   parameter int N_LEDS        = N_LEDS_DEF,
   parameter int PWM_BITS      = PWM_BITS_DEF,
   parameter int FADE_DIV_LOG2 = FADE_DIV_LOG2_DEF,
   parameter int FADE_STEP     = FADE_STEP_DEF
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_LEDS-1:0]   pattern_in,
   input  logic [PWM_BITS-1:0] bright_max,
   output logic [N_LEDS-1:0]   led_out,
   output logic                fade_tick
);

   logic [PWM_BITS-1:0]      pwm_cnt_r;
   logic [FADE_DIV_LOG2-1:0] prescaler_r;
   logic                     fade_tick_r;
   logic                     boundary_s;

   // Free-running PWM counter, fade prescaler and the registered fade strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_r   <= {PWM_BITS{1'b0}};
         prescaler_r <= {FADE_DIV_LOG2{1'b0}};
         fade_tick_r <= 1'b0;
      end else begin
         pwm_cnt_r   <= pwm_cnt_r + {{(PWM_BITS-1){1'b0}}, 1'b1};
         prescaler_r <= prescaler_r + {{(FADE_DIV_LOG2-1){1'b0}}, 1'b1};
         fade_tick_r <= &prescaler_r;
      end
   end

   assign boundary_s = (pwm_cnt_r == {PWM_BITS{1'b1}});
   assign fade_tick  = fade_tick_r;

   for (genvar i = 0; i < N_LEDS; i++) begin : gen_ch
      led_pwm_channel #(
         .PWM_BITS  (PWM_BITS),
         .FADE_STEP (FADE_STEP)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .pattern_bit (pattern_in[i]),
         .bright_max  (bright_max),
         .pwm_cnt     (pwm_cnt_r),
         .boundary    (boundary_s),
         .fade_tick   (fade_tick_r),
         .led         (led_out[i])
      );
   end

endmodule

// File: tb/tb_led_afterglow_pwm.sv
// Directed self-checking bench for led_afterglow_pwm (fast fade: tick every 16 clocks, step 16).
module tb_led_afterglow_pwm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pattern_in = 8'h00;
   logic [7:0] bright_max = 8'h00;
   logic [7:0] led_out;
   logic       fade_tick;

   int checks = 0;
   int passed = 0;

   logic [7:0]      tb_cnt;
   logic [7:0][7:0] lv;

   led_afterglow_pwm #(
      .N_LEDS        (8),
      .PWM_BITS      (8),
      .FADE_DIV_LOG2 (4),
      .FADE_STEP     (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pattern_in (pattern_in),
      .bright_max (bright_max),
      .led_out    (led_out),
      .fade_tick  (fade_tick)
   );

   always #5 clk = ~clk;

   // Expected PWM phase: clock edges since reset release, modulo 256.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cnt <= 8'd0;
      else        tb_cnt <= tb_cnt + 8'd1;
   end

   for (genvar g = 0; g < 8; g++) begin : g_lv
      assign lv[g] = dut.gen_ch[g].u_ch.level_r;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cnt(input logic [7:0] v);
      int n;
      n = 0;
      step();
      while (tb_cnt !== v && n < 600) begin
         step();
         n++;
      end
      if (tb_cnt !== v) begin
         checks++;
         $display("FAIL wait_cnt: phase %0d never reached", v);
      end
   endtask

   task automatic do_reset(input logic [7:0] pat, input logic [7:0] br);
      rst_n      = 1'b0;
      pattern_in = pat;
      bright_max = br;
      repeat (3) step();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      pattern_in = 8'hFF;
      bright_max = 8'd255;
      rst_n      = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         checks++;
         if (led_out !== 8'h00 || fade_tick !== 1'b0)
            $display("FAIL reset_hold: cycle %0d led_out=%h fade_tick=%b, required 00/0", i, led_out, fade_tick);
         else passed++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         step();
         checks++;
         if (led_out !== 8'h00)
            $display("FAIL reset_release_dark: edge %0d led_out=%h, required 00", k, led_out);
         else passed++;
      end
      step();
      checks++;
      if (led_out !== 8'hFF)
         $display("FAIL reset_first_light: led_out=%h, required ff", led_out);
      else passed++;
   endtask

   task automatic test_steady_duty();
      int highs;
      logic exp_bit;
      do_reset(8'h01, 8'd64);
      wait_cnt(8'd0);
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         exp_bit = (tb_cnt >= 8'd1 && tb_cnt <= 8'd64);
         checks++;
         if (led_out !== {7'b0, exp_bit})
            $display("FAIL steady_duty: phase %0d led_out=%h, required %h", tb_cnt, led_out, {7'b0, exp_bit});
         else passed++;
         if (led_out[0] === 1'b1) highs++;
         step();
      end
      checks++;
      if (highs !== 64)
         $display("FAIL steady_duty_count: high cycles=%0d, required 64", highs);
      else passed++;
   endtask

   task automatic test_fade();
      int ticks;
      logic [7:0] prev;
      logic       ft;
      logic [7:0] exp_lv;
      do_reset(8'h00, 8'd255);
      step();
      pattern_in = 8'h08;
      step();
      pattern_in = 8'h00;
      step();
      step();
      checks++;
      if (lv[3] !== 8'd255)
         $display("FAIL fade_start: level3=%0d, required 255", lv[3]);
      else passed++;
      ticks = 0;
      for (int i = 0; i < 400; i++) begin
         prev = lv[3];
         ft   = fade_tick;
         step();
         if (ft && prev != 8'd0) begin
            exp_lv = (ticks < 15) ? 8'(255 - 16 * (ticks + 1)) : 8'd0;
            ticks++;
         end else begin
            exp_lv = prev;
         end
         checks++;
         if (lv[3] !== exp_lv)
            $display("FAIL fade_step: tick %0d level3=%0d, required %0d", ticks, lv[3], exp_lv);
         else passed++;
      end
      checks++;
      if (ticks !== 16 || lv[3] !== 8'd0)
         $display("FAIL fade_ticks: ticks=%0d level3=%0d, required 16 and 0", ticks, lv[3]);
      else passed++;
      wait_cnt(8'd0);
      for (int i = 0; i < 256; i++) begin
         checks++;
         if (led_out[3] !== 1'b0)
            $display("FAIL fade_dark: phase %0d led_out[3]=%b, required 0", tb_cnt, led_out[3]);
         else passed++;
         step();
      end
   endtask

   task automatic test_set_vs_tick();
      do_reset(8'h20, 8'd100);
      wait_cnt(8'd4);
      pattern_in = 8'h00;
      wait_cnt(8'd15);
      checks++;
      if (lv[5] !== 8'd100)
         $display("FAIL set_tick_setup: level5=%0d, required 100", lv[5]);
      else passed++;
      pattern_in = 8'h20;
      bright_max = 8'd200;
      step();
      checks++;
      if (fade_tick !== 1'b1 || lv[5] !== 8'd100)
         $display("FAIL set_tick_align: fade_tick=%b level5=%0d, required 1 and 100", fade_tick, lv[5]);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (lv[5] !== 8'd200)
            $display("FAIL set_wins: level5=%0d, required 200", lv[5]);
         else passed++;
      end
   endtask

   task automatic test_glitch_free();
      int runs [4];
      int nruns;
      int run;
      logic changed;
      do_reset(8'h01, 8'd200);
      wait_cnt(8'd0);
      nruns = 0;
      run = 0;
      changed = 1'b0;
      for (int i = 0; i < 4; i++) runs[i] = 0;
      for (int i = 0; i < 768; i++) begin
         if (tb_cnt == 8'd30 && !changed) begin
            bright_max = 8'd50;
            changed = 1'b1;
         end
         if (led_out[0] === 1'b1) begin
            run++;
         end else if (run > 0) begin
            if (nruns < 4) runs[nruns] = run;
            nruns++;
            run = 0;
         end
         step();
      end
      checks++;
      if (nruns !== 3)
         $display("FAIL glitch_pulse_count: pulses=%0d, required 3", nruns);
      else passed++;
      checks++;
      if (runs[0] !== 200)
         $display("FAIL glitch_current_period: pulse=%0d, required 200", runs[0]);
      else passed++;
      checks++;
      if (runs[1] !== 50 || runs[2] !== 50)
         $display("FAIL glitch_new_period: pulses=%0d,%0d, required 50,50", runs[1], runs[2]);
      else passed++;
   endtask

   task automatic test_async_reset();
      do_reset(8'hFF, 8'd255);
      wait_cnt(8'd0);
      wait_cnt(8'd100);
      checks++;
      if (led_out !== 8'hFF)
         $display("FAIL async_pre_lit: led_out=%h, required ff", led_out);
      else passed++;
      pattern_in = 8'h00;
      wait_cnt(8'd110);
      checks++;
      if (led_out !== 8'hFF)
         $display("FAIL async_mid_fade_lit: led_out=%h, required ff", led_out);
      else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (led_out !== 8'h00 || fade_tick !== 1'b0)
         $display("FAIL async_clear: led_out=%h fade_tick=%b, required 00/0", led_out, fade_tick);
      else passed++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      for (int g = 0; g < 8; g++) begin
         checks++;
         if (lv[g] !== 8'd0)
            $display("FAIL async_level_clear: level%0d=%0d, required 0", g, lv[g]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_steady_duty();
      test_fade();
      test_set_vs_tick();
      test_glitch_free();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/led_afterglow_pwm.md
Name: led_afterglow_pwm

Overview:
- Drives the board LED bank (LED1..LED8) from an 8-bit on/off pattern, such as a gray-code counter or a random-number display.
- Each lit bit sets its LED to a programmable brightness.
- When the bit drops, the LED fades out linearly instead of switching off.
- Brightness is produced by per-LED PWM, updated glitch-free at PWM period boundaries.

Parameters:
- N_LEDS, 8, number of LED channels.
- PWM_BITS, 8, PWM counter and brightness width; period is 2^PWM_BITS clocks.
- FADE_DIV_LOG2, 16, fade tick occurs every 2^FADE_DIV_LOG2 clocks.
- FADE_STEP, 8, brightness decrement per fade tick; range 1..2^PWM_BITS-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pattern_in  in  N_LEDS  on/off request per LED, synchronous to clk.
- bright_max  in  PWM_BITS  brightness used for lit LEDs.
- led_out  out  N_LEDS  PWM-modulated LED drive, registered.
- fade_tick  out  1  one-cycle strobe when fade is applied, for debug.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low; the clock and reset ports are named clk and rst_n.
- Reset values: led_out=0, fade_tick=0, pwm_cnt=0, prescaler=0, every level[i]=0, every duty[i]=0, pattern_q=0.
- pattern_in is registered into pattern_q with 1 cycle of latency.
- pwm_cnt is a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0. "Boundary" means pwm_cnt == 2^PWM_BITS-1.
- The prescaler is a free-running FADE_DIV_LOG2-bit counter. fade_tick is registered and is high for the cycle after the prescaler reaches all-ones.
- level[i] update, per clock, evaluated in priority order:
  1. pattern_q[i]=1: level[i] <= bright_max. This tracks bright_max every cycle.
  2. Else if fade_tick=1: level[i] <= (level[i] > FADE_STEP) ? level[i]-FADE_STEP : 0. The subtraction saturates at 0 and never wraps.
  3. Else if level[i] > bright_max: level[i] <= bright_max. A lowered cap clamps fading LEDs.
  4. Else: hold.
- Simultaneous set and fade_tick: set wins and no decrement is applied.
- duty[i] <= level[i] only at a boundary, so a pulse is never truncated or extended mid-period.
- led_out[i] <= (pwm_cnt < duty[i]), registered.
  - duty=0 gives a constantly low output.
  - duty=2^PWM_BITS-1 gives high for 2^PWM_BITS-1 of every 2^PWM_BITS clocks.
- Latency from pattern_in rising to first led_out high:
  - 2 cycles to reach level.
  - then wait for the next boundary.
  - then 1 cycle for duty and 1 cycle for the output register.
  - Worst case is 2^PWM_BITS+3 clocks.
- Within a period, the high pulse starts on the cycle after pwm_cnt=0 and has length exactly duty[i].
- Fade-out time from level L is ceil(L/FADE_STEP) ticks, plus up to one PWM period before led_out reaches steady 0.
- Reset asserted mid-operation clears all registers asynchronously. led_out goes low without waiting for a clock edge.
- After reset release, no LED lights before the first boundary.
- Channels are fully independent; the only shared state is pwm_cnt and fade_tick.

Decomposition:
- Shared package led_pkg contains:
  - default PWM_BITS and N_LEDS;
  - the fade default constants;
  - a typedef for the brightness level, logic [PWM_BITS-1:0].
- Sub-module led_pwm_channel holds one channel: pattern bit, level register, duty latch and compare/output flop. Its inputs are pwm_cnt, boundary, fade_tick and bright_max.
- The top module holds pwm_cnt, the prescaler and fade_tick, and generates N_LEDS instances of led_pwm_channel.

Test Plan:
- Reset: hold rst_n=0 with pattern_in=8'hFF and bright_max=255 for 300 clocks.
  -> led_out=0 and fade_tick=0 throughout.
  -> After release, led_out stays 0 until the first boundary plus 2 cycles.
- Steady duty: bright_max=64, pattern_in=8'h01 held.
  -> After settling, led_out[0] is high exactly 64 of every 256 clocks, contiguous, starting the cycle after pwm_cnt=0.
  -> led_out[7:1]=0.
- Fade: FADE_DIV_LOG2=4, FADE_STEP=16, bright_max=255; pulse pattern_in[3] for one cycle.
  -> level[3] sequence on successive fade_ticks is 255, 239, 223, ..., 15, 0.
  -> There are 16 ticks in total and the last step saturates from 15 to 0.
  -> Once duty is 0, led_out[3] stays 0.
- Set vs tick: assert pattern_in[5] so pattern_q[5]=1 lands on the same cycle as fade_tick=1, with level[5]=100 and bright_max=200.
  -> Next level[5]=200; the value 92 is never seen.
- Glitch-free update: LED held lit, bright_max changed from 200 to 50 at pwm_cnt=30.
  -> The current period's pulse is 200 clocks long.
  -> Every following period's pulse is 50 clocks long.
  -> No pulse of any other length occurs.
- Async reset mid-fade: drop rst_n between clock edges while led_out=8'hFF.
  -> led_out=0 before the next clk edge; all levels read 0 after release.
